implication_responder: RTL and testbench
========================================

Name: implication_responder

Overview:
- Responder side of the antecedent/consequent property pair: drives `consequent` so that every accepted `antecedent` is answered exactly L cycles later.
- L=0 gives overlapping (|->) behaviour; L=1 gives non-overlapping (|=>) behaviour; L up to MAX_LATENCY gives delayed behaviour.
- Sits in the formal and simulation harnesses as the design under check for the implication assertions.
- Optional fault injection lets the checkers be shown to fail.

Parameters:
- MAX_LATENCY, 4, largest supported response delay in cycles (>=1).
- CNT_W, 8, width of the served/dropped counters.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- latency_cfg  input  $clog2(MAX_LATENCY+1)  requested delay L; values above MAX_LATENCY saturate to MAX_LATENCY.
- antecedent  input  1  request.
- inject_drop  input  1  when high together with antecedent, that request is never answered.
- inject_spurious  input  1  forces consequent=1 on the following cycle.
- consequent  output  1  response.
- busy  output  1  at least one response is pending.
- lat_active  output  $clog2(MAX_LATENCY+1)  latency currently in force.
- served_count  output  CNT_W  genuine responses issued, saturating.
- dropped_count  output  CNT_W  requests dropped by injection, saturating.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; delay line cleared; lat_active=1; counters=0; spurious flag=0.
  - While rst is high, consequent=0 and busy=0, including the L=0 combinational path.
- State machine has two states:
  - IDLE: delay line empty. Each cycle, lat_active <= sat(latency_cfg).
  - BUSY: delay line non-empty. lat_active is held and latency_cfg is ignored.
- Transitions:
  - IDLE->BUSY when an accepted request enters the delay line (L>=1).
  - BUSY->IDLE when the line empties on that cycle with no new entry.
  - A latency change therefore never reorders or loses pending responses.
- L=0:
  - consequent = antecedent & ~inject_drop & ~rst, combinational.
  - busy stays 0; FSM stays in IDLE.
- L>=1:
  - Delay line of MAX_LATENCY bits. An accepted request at cycle t writes the slot that reaches the output at cycle t+L.
  - Back-to-back requests on consecutive cycles are all answered on consecutive cycles. There is no overflow: one slot per cycle.
- Accepted request: antecedent=1 and inject_drop=0. When antecedent=1 and inject_drop=1, dropped_count increments and nothing enters the line. inject_drop with antecedent=0 has no effect.
- Spurious injection:
  - inject_spurious=1 at cycle t sets a flag, and consequent=1 at t+1.
  - If a genuine response is also due at t+1, consequent is 1 (one pulse) and served_count increments by 1.
  - Spurious pulses never increment served_count.
- consequent = delay-line head | spurious flag (registered path) for L>=1.
- busy = delay line non-empty.
- Counters saturate at all-ones; no wrap-around.
- Reset mid-operation: all pending responses are discarded and no consequent appears afterward. The first cycle after reset behaves as IDLE with lat_active=1.
- latency_cfg changes in BUSY take effect on the first IDLE cycle. A request arriving in that same cycle uses the new value.

Decomposition:
- Shared package implication_pkg holds:
  - typedef enum {OVERLAPPING, NON_OVERLAPPING} implication_kind_e.
  - typedef enum {IDLE, BUSY} responder_state_e.
  - function sat_latency.
- One sub-module: implication_delay_line (parameterised shift register with insert-at-offset, head output and empty flag).

Test Plan:
- Reset, then latency_cfg=1 and antecedent pulse at cycle 5 -> consequent=1 only at cycle 6; busy=1 at cycle 6 only; served_count=1.
- latency_cfg=0, antecedent high for cycles 3-5 -> consequent high during cycles 3-5 in the same cycle; busy never asserts.
- latency_cfg=3, antecedent at cycles 10,11,12; latency_cfg changed to 1 at cycle 11 -> consequent at 13,14,15; lat_active stays 3 until IDLE at cycle 16, then reads 1.
- latency_cfg=2, antecedent+inject_drop at cycle 4 -> no consequent at 6; dropped_count=1; served_count=0.
- latency_cfg=2, antecedent at 7 and inject_spurious at 8 -> single consequent pulse at 9; served_count=1. A lone inject_spurious at 20 -> consequent at 21 with served_count unchanged.
- latency_cfg=4, antecedent at 2, rst at 4 -> consequent stays 0 through cycle 10; counters=0; lat_active=1.

Source files
------------

// File: rtl/implication_pkg.sv
// Shared types and helpers for the implication responder and its delay line.
package implication_pkg;

   typedef enum logic {OVERLAPPING, NON_OVERLAPPING} implication_kind_e;

   typedef enum logic {IDLE, BUSY} responder_state_e;

   function automatic int sat_latency(input int cfg, input int max_lat);
      return (cfg > max_lat) ? max_lat : cfg;
   endfunction

endpackage

// File: rtl/implication_delay_line.sv
// Response delay line: shifts toward slot 0 (head) each cycle; an insert with
// offset L lands in slot L-1 so it reaches the head L cycles later.
module implication_delay_line #(
   parameter int DEPTH = 4,
   parameter int LW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          insert,
   input  logic [LW-1:0] offset,
   output logic          head,
   output logic          empty,
   output logic          drain
);

   logic [DEPTH-1:0] line_q;
   logic [DEPTH-1:0] line_d;

   always_comb begin
      line_d = line_q >> 1;
      for (int i = 0; i < DEPTH; i++) begin
         if (insert && (int'(offset) == i + 1)) begin
            line_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign head  = line_q[0];
   assign empty = (line_q == '0);
   // drain: the line will be empty next cycle
   assign drain = (line_d == '0);

endmodule

// File: rtl/implication_responder.sv
// Answers every accepted antecedent with a consequent exactly L cycles later,
// with fault injection (drop / spurious) and saturating served/dropped counters.
//
// state | meaning
// IDLE  | delay line empty; lat_active tracks sat(latency_cfg)
// BUSY  | responses pending; lat_active frozen, latency_cfg ignored
module implication_responder
   import implication_pkg::*;
#(
   parameter  int MAX_LATENCY = 4,
   parameter  int CNT_W       = 8,
   localparam int LW          = $clog2(MAX_LATENCY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LW-1:0]    latency_cfg,
   input  logic             antecedent,
   input  logic             inject_drop,
   input  logic             inject_spurious,
   output logic             consequent,
   output logic             busy,
   output logic [LW-1:0]    lat_active,
   output logic [CNT_W-1:0] served_count,
   output logic [CNT_W-1:0] dropped_count
);

   responder_state_e  state, state_nxt;
   implication_kind_e kind;
   logic [LW-1:0]     lat_cfg_sat;
   logic [LW-1:0]     lat_eff;
   logic              accepted;
   logic              insert;
   logic              genuine;
   logic              spur_q;
   logic              line_head, line_empty, line_drain;

   assign lat_cfg_sat = LW'(sat_latency(int'(latency_cfg), MAX_LATENCY));
   // A request in the first IDLE cycle already uses the new configuration.
   assign lat_eff     = (state == IDLE) ? lat_cfg_sat : lat_active;
   assign accepted    = antecedent & ~inject_drop & ~rst;

   implication_delay_line #(
      .DEPTH (MAX_LATENCY),
      .LW    (LW)
   ) u_line (
      .clk    (clk),
      .rst    (rst),
      .insert (insert),
      .offset (lat_eff),
      .head   (line_head),
      .empty  (line_empty),
      .drain  (line_drain)
   );

   always_comb begin
      state_nxt  = state;
      kind       = (lat_eff == '0) ? OVERLAPPING : NON_OVERLAPPING;
      insert     = accepted & (kind == NON_OVERLAPPING);
      genuine    = 1'b0;
      consequent = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: if (insert) state_nxt = BUSY;
         BUSY: if (line_drain) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!rst) begin
         genuine    = (kind == OVERLAPPING) ? accepted : line_head;
         consequent = genuine | spur_q;
         busy       = ~line_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         lat_active    <= LW'(1);
         spur_q        <= 1'b0;
         served_count  <= '0;
         dropped_count <= '0;
      end else begin
         state  <= state_nxt;
         spur_q <= inject_spurious;
         if (state == IDLE) begin
            lat_active <= lat_cfg_sat;
         end
         if (genuine && (served_count != '1)) begin
            served_count <= served_count + CNT_W'(1);
         end
         if (antecedent && inject_drop && (dropped_count != '1)) begin
            dropped_count <= dropped_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_implication_responder.sv
// Scoreboard bench: scenarios push per-cycle expectations, a negedge monitor
// pops and compares them against the responder outputs.
module tb_implication_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] latency_cfg = 3'd0;
   logic       antecedent = 1'b0;
   logic       inject_drop = 1'b0;
   logic       inject_spurious = 1'b0;
   logic       consequent;
   logic       busy;
   logic [2:0] lat_active;
   logic [7:0] served_count;
   logic [7:0] dropped_count;

   implication_responder #(.MAX_LATENCY(4), .CNT_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .latency_cfg     (latency_cfg),
      .antecedent      (antecedent),
      .inject_drop     (inject_drop),
      .inject_spurious (inject_spurious),
      .consequent      (consequent),
      .busy            (busy),
      .lat_active      (lat_active),
      .served_count    (served_count),
      .dropped_count   (dropped_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      bit         cons;
      bit         bsy;
      bit         chk_lat;
      logic [2:0] lat;
      bit         chk_cnt;
      logic [7:0] srv;
      logic [7:0] drp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   base   = 0;

   task automatic push(input int rel, input bit cons, input bit bsy,
                       input bit cl, input logic [2:0] lat,
                       input bit cc, input int srv, input int drp);
      exp_t e;
      e.cyc = base + rel; e.cons = cons; e.bsy = bsy;
      e.chk_lat = cl; e.lat = lat;
      e.chk_cnt = cc; e.srv = 8'(srv); e.drp = 8'(drp);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         chk("missed_expectation", cyc, e.cyc);
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         chk("consequent", int'(consequent), int'(e.cons));
         chk("busy", int'(busy), int'(e.bsy));
         if (e.chk_lat) chk("lat_active", int'(lat_active), int'(e.lat));
         if (e.chk_cnt) begin
            chk("served_count", int'(served_count), int'(e.srv));
            chk("dropped_count", int'(dropped_count), int'(e.drp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] cfg);
      rst = 1'b1; latency_cfg = cfg;
      antecedent = 1'b0; inject_drop = 1'b0; inject_spurious = 1'b0;
      tick(); tick();
      rst  = 1'b0;
      base = cyc;
   endtask

   initial begin
      int budget;

      // L=1: single pulse answered next cycle
      start(3'd1);
      for (int r = 0; r < 10; r++)
         push(r, r == 6, r == 6, r == 0, 3'd1, r == 0 || r == 9, (r >= 7) ? 1 : 0, 0);
      for (int r = 0; r < 10; r++) begin antecedent = (r == 5); tick(); end

      // L=0: overlapping, combinational, never busy
      start(3'd0);
      for (int r = 0; r < 9; r++)
         push(r, r >= 3 && r <= 5, 1'b0, r == 2, 3'd0, r == 7, 3, 0);
      for (int r = 0; r < 9; r++) begin antecedent = (r >= 3 && r <= 5); tick(); end

      // L=3 burst with latency change while BUSY
      start(3'd3);
      for (int r = 0; r < 19; r++)
         push(r, r >= 13 && r <= 15, r >= 11 && r <= 15,
              r == 12 || r == 15 || r == 17, (r == 17) ? 3'd1 : 3'd3,
              r == 17, 3, 0);
      for (int r = 0; r < 19; r++) begin
         antecedent  = (r >= 10 && r <= 12);
         latency_cfg = (r >= 11) ? 3'd1 : 3'd3;
         tick();
      end

      // Dropped request; drop without antecedent is ignored
      start(3'd2);
      for (int r = 0; r < 10; r++)
         push(r, 1'b0, 1'b0, 1'b0, 3'd0, r == 5 || r == 9, 0, 1);
      for (int r = 0; r < 10; r++) begin
         antecedent  = (r == 4);
         inject_drop = (r == 4 || r == 7);
         tick();
      end

      // Spurious merged with genuine response, then lone spurious
      start(3'd2);
      for (int r = 0; r < 25; r++)
         push(r, r == 9 || r == 21, r == 8 || r == 9, r == 5, 3'd2,
              r == 11 || r == 23, 1, 0);
      for (int r = 0; r < 25; r++) begin
         antecedent      = (r == 7);
         inject_spurious = (r == 8 || r == 20);
         tick();
      end

      // Reset mid-operation discards pending response
      start(3'd4);
      for (int r = 0; r < 11; r++)
         push(r, 1'b0, r == 3, r == 5, 3'd1, r == 5 || r == 10, 0, 0);
      for (int r = 0; r < 11; r++) begin
         antecedent = (r == 2);
         rst        = (r == 4);
         tick();
      end

      // Out-of-range latency saturates to 4
      start(3'd7);
      for (int r = 0; r < 8; r++)
         push(r, r == 5, r >= 2 && r <= 5, r == 0 || r == 3,
              (r == 0) ? 3'd1 : 3'd4, r == 7, 1, 0);
      for (int r = 0; r < 8; r++) begin antecedent = (r == 1); tick(); end

      // Served counter saturates at 255
      start(3'd0);
      for (int r = 0; r < 263; r++)
         push(r, r < 260, 1'b0, 1'b0, 3'd0, r == 100 || r == 262,
              (r == 100) ? 100 : 255, 0);
      for (int r = 0; r < 263; r++) begin antecedent = (r < 260); tick(); end

      antecedent = 1'b0;
      budget = 0;
      while (exp_q.size() != 0 && budget < 10) begin tick(); budget++; end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
